// File: rtl/traffic_light_pkg.sv
// Shared types for the highway/farm-road intersection controller:
// controller states, one-hot lamp codes and the state-to-lamp decode.
package traffic_light_pkg;

  localparam int unsigned LAMP_W = 3;

  typedef enum logic [1:0] {
    HG = 2'd0,
    HY = 2'd1,
    FG = 2'd2,
    FY = 2'd3
  } state_t;

  localparam logic [LAMP_W-1:0] LAMP_GREEN  = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_RED    = 3'b100;

  typedef struct packed {
    logic [LAMP_W-1:0] highway;
    logic [LAMP_W-1:0] farm;
  } lamps_t;

  // Moore decode; every state shows red on at least one road
  function automatic lamps_t lamp_decode(input state_t st);
    lamps_t l;
    l.highway = LAMP_GREEN;
    l.farm    = LAMP_RED;
    case (st)
      HG: begin l.highway = LAMP_GREEN;  l.farm = LAMP_RED;    end
      HY: begin l.highway = LAMP_YELLOW; l.farm = LAMP_RED;    end
      FG: begin l.highway = LAMP_RED;    l.farm = LAMP_GREEN;  end
      FY: begin l.highway = LAMP_RED;    l.farm = LAMP_YELLOW; end
      default: begin l.highway = LAMP_GREEN; l.farm = LAMP_RED; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_timer.sv
// Clearable saturating up-counter timing phase dwell; done_c rises once
// `limit` cycles have elapsed since the last clear (or reset).
module traffic_light_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         done_c
);

  logic [W-1:0] count;

  // count never exceeds limit-1, so count+1 cannot overflow W bits
  assign done_c = (count + W'(1)) >= limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!done_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light.sv
// Highway/farm-road intersection controller (Moore FSM, registered lamps).
// Optional build macro TRAFFIC_LIGHT_MIN_GREEN_EN enforces a minimum highway green.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES    = 4,
  parameter int unsigned MIN_GREEN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S,
  output logic [LAMP_W-1:0] light_highway,
  output logic [LAMP_W-1:0] light_farm
);

`ifdef TRAFFIC_LIGHT_MIN_GREEN_EN
  localparam int unsigned HG_DWELL = MIN_GREEN_CYCLES;
`else
  // a one-cycle dwell makes the timer always done in HG: no minimum green
  localparam int unsigned HG_DWELL = 1;
`endif
  localparam int unsigned TIMER_MAX = (HG_DWELL > YELLOW_CYCLES) ? HG_DWELL : YELLOW_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  if (YELLOW_CYCLES < 1 || MIN_GREEN_CYCLES < 1) begin : g_bad_params
    $error("traffic_light: YELLOW_CYCLES and MIN_GREEN_CYCLES must be >= 1");
  end

  state_t               state;
  state_t               state_next;
  lamps_t               lamps_next;
  logic                 timer_clear;
  logic [TIMER_W-1:0]   timer_limit;
  logic                 timer_done_c;

  traffic_light_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .limit  (timer_limit),
    .done_c (timer_done_c)
  );

  // State and lamp registers; lamps are loaded with the decode of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HG;
      light_highway <= LAMP_GREEN;
      light_farm    <= LAMP_RED;
    end else begin
      state         <= state_next;
      light_highway <= lamps_next.highway;
      light_farm    <= lamps_next.farm;
    end
  end

  // Next-state logic; the timer restarts on every phase change
  always_comb begin
    state_next  = state;
    timer_limit = TIMER_W'(YELLOW_CYCLES);
    case (state)
      HG: begin
        timer_limit = TIMER_W'(HG_DWELL);
        if (S && timer_done_c) state_next = HY;
      end
      HY: if (timer_done_c) state_next = FG;
      FG: if (!S) state_next = FY;
      FY: if (timer_done_c) state_next = HG;
      default: state_next = HG;
    endcase
    timer_clear = (state_next != state);
    lamps_next  = lamp_decode(state_next);
  end

endmodule

// File: tb/tb_traffic_light.sv
// Self-checking bench for traffic_light: directed scenarios plus randomized
// sensor/reset stimulus against a right-of-way model of the intersection.
module tb_traffic_light;

  localparam int unsigned YC = 4;
  localparam int unsigned MG = 8;
`ifdef TRAFFIC_LIGHT_MIN_GREEN_EN
  localparam int unsigned HG_MIN = MG;
`else
  localparam int unsigned HG_MIN = 1;
`endif

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s   = 1'b0;
  logic [2:0] hw;
  logic [2:0] fm;

  int passed = 0;
  int total  = 0;

  // model: which road holds right of way, yellow cycles left, time in highway green
  bit m_farm_row;
  int m_yellow_left;
  int m_hg_age;

  traffic_light #(
    .YELLOW_CYCLES    (YC),
    .MIN_GREEN_CYCLES (MG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S             (s),
    .light_highway (hw),
    .light_farm    (fm)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_farm_row    = 1'b0;
    m_yellow_left = 0;
    m_hg_age      = 0;
  endtask

  task automatic model_step(input bit sv);
    if (m_yellow_left > 0) begin
      m_yellow_left--;
      if (m_yellow_left == 0) begin
        m_farm_row = ~m_farm_row;
        m_hg_age   = 0;
      end
    end else if (!m_farm_row) begin
      if (sv && (m_hg_age + 1 >= int'(HG_MIN))) m_yellow_left = YC;
      else m_hg_age++;
    end else if (!sv) begin
      m_yellow_left = YC;
    end
  endtask

  function automatic logic [5:0] model_lamps();
    logic [2:0] active;
    active = (m_yellow_left > 0) ? LY : LG;
    return m_farm_row ? {LR, active} : {active, LR};
  endfunction

  // drive S, clock once, advance the model, sample 1 time unit after the edge
  task automatic tick(input bit sv);
    s = sv;
    @(posedge clk);
    model_step(sv);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    s = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({hw, fm} !== {LG, LR}) $display("FAIL reset_async: got %b/%b expected %b/%b", hw, fm, LG, LR);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({hw, fm} !== {LG, LR}) $display("FAIL reset_held: got %b/%b expected %b/%b", hw, fm, LG, LR);
    else passed++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0);
      total++;
      if ({hw, fm} !== {LG, LR}) $display("FAIL reset_idle: got %b/%b expected %b/%b", hw, fm, LG, LR);
      else passed++;
    end
  endtask

  task automatic test_request();
    int waited = 0;
    int ylen = 0;
    tick(1'b1);
    while (hw === LG && waited < 40) begin
      waited++;
      tick(1'b1);
    end
    while (hw === LY && ylen < 40) begin
      total++;
      if ({hw, fm} !== model_lamps()) $display("FAIL request_model: got %b/%b expected %b", hw, fm, model_lamps());
      else passed++;
      ylen++;
      tick(1'b1);
    end
    total++;
    if (ylen != int'(YC)) $display("FAIL request_yellow_len: got %0d expected %0d", ylen, YC);
    else passed++;
    total++;
    if ({hw, fm} !== {LR, LG}) $display("FAIL request_farm_green: got %b/%b expected %b/%b", hw, fm, LR, LG);
    else passed++;
  endtask

  task automatic test_hold_release();
    int ylen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      total++;
      if ({hw, fm} !== {LR, LG}) $display("FAIL hold_farm_green: got %b/%b expected %b/%b", hw, fm, LR, LG);
      else passed++;
    end
    tick(1'b0);
    while (fm === LY && ylen < 40) begin
      total++;
      if ({hw, fm} !== model_lamps()) $display("FAIL release_model: got %b/%b expected %b", hw, fm, model_lamps());
      else passed++;
      ylen++;
      tick(1'b0);
    end
    total++;
    if (ylen != int'(YC)) $display("FAIL release_yellow_len: got %0d expected %0d", ylen, YC);
    else passed++;
    total++;
    if ({hw, fm} !== {LG, LR}) $display("FAIL release_highway_green: got %b/%b expected %b/%b", hw, fm, LG, LR);
    else passed++;
  endtask

  task automatic test_yellow_immunity();
    int guard = 0;
    int ylen = 0;
    bit t = 1'b0;
    while (hw !== LY && guard < 40) begin
      guard++;
      tick(1'b1);
    end
    while (hw === LY && ylen < 40) begin
      ylen++;
      tick(t);
      t = ~t;
      total++;
      if ({hw, fm} !== model_lamps()) $display("FAIL immunity_hy_model: got %b/%b expected %b", hw, fm, model_lamps());
      else passed++;
    end
    total++;
    if (ylen != int'(YC)) $display("FAIL immunity_hy_len: got %0d expected %0d", ylen, YC);
    else passed++;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    ylen = 0;
    while (fm === LY && ylen < 40) begin
      ylen++;
      tick(t);
      t = ~t;
      total++;
      if ({hw, fm} !== model_lamps()) $display("FAIL immunity_fy_model: got %b/%b expected %b", hw, fm, model_lamps());
      else passed++;
    end
    total++;
    if (ylen != int'(YC)) $display("FAIL immunity_fy_len: got %0d expected %0d", ylen, YC);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(m_farm_row && m_yellow_left == 0) && guard < 40) begin
      guard++;
      tick(1'b1);
    end
    tick(1'b1);
    total++;
    if ({hw, fm} !== {LR, LG}) $display("FAIL mid_reset_fg_entry: got %b/%b expected %b/%b", hw, fm, LR, LG);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({hw, fm} !== {LG, LR}) $display("FAIL reset_in_fg: got %b/%b expected %b/%b", hw, fm, LG, LR);
    else passed++;
    release_reset();
    tick(1'b1);
    total++;
    if ({hw, fm} !== model_lamps()) $display("FAIL post_reset_request: got %b/%b expected %b", hw, fm, model_lamps());
    else passed++;
    guard = 0;
    while (!(m_farm_row && m_yellow_left == 0) && guard < 40) begin
      guard++;
      tick(1'b1);
    end
    tick(1'b0);
    tick(1'b1);
    total++;
    if ({hw, fm} !== {LR, LY}) $display("FAIL mid_reset_fy_entry: got %b/%b expected %b/%b", hw, fm, LR, LY);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({hw, fm} !== {LG, LR}) $display("FAIL reset_in_fy: got %b/%b expected %b/%b", hw, fm, LG, LR);
    else passed++;
    release_reset();
  endtask

`ifdef TRAFFIC_LIGHT_MIN_GREEN_EN
  task automatic test_min_green();
    int greens = 0;
    rst = 1'b1;
    #1;
    release_reset();
    tick(1'b1);
    while (hw === LG && greens < 40) begin
      greens++;
      tick(1'b1);
    end
    // the interval from release to the first edge is the first green cycle
    total++;
    if (greens + 1 != int'(MG)) $display("FAIL min_green_len: got %0d expected %0d", greens + 1, MG);
    else passed++;
  endtask
`endif

  task automatic test_random();
    bit sv = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b1;
        #1;
        total++;
        if ({hw, fm} !== {LG, LR}) $display("FAIL random_reset: got %b/%b expected %b/%b", hw, fm, LG, LR);
        else passed++;
        release_reset();
      end
      if ($urandom_range(0, 99) < 20) sv = ~sv;
      tick(sv);
      total++;
      if ({hw, fm} !== model_lamps()) $display("FAIL random_model: got %b/%b expected %b", hw, fm, model_lamps());
      else passed++;
      total++;
      if (!(hw === LR || fm === LR) || (hw === LG && fm === LG))
        $display("FAIL invariant: got %b/%b expected one road red", hw, fm);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_request();
    test_hold_release();
    test_yellow_immunity();
    test_mid_reset();
`ifdef TRAFFIC_LIGHT_MIN_GREEN_EN
    test_min_green();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
# traffic_light

Highway/farm-road intersection controller: a Moore state machine that keeps the highway green until a farm-road car sensor requests service. It then sequences through yellow to give the farm road green, and returns to the highway when the sensor clears. It sits standalone at the top of the intersection design, driving two one-hot lamp buses.

## Interface
Parameters:
- YELLOW_CYCLES, default 4: number of clock cycles each yellow phase lasts (≥1).
- MIN_GREEN_CYCLES, default 8: minimum highway-green dwell, used only when TRAFFIC_LIGHT_MIN_GREEN_EN is defined (≥1).

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge system clock.
- rst  input  1  asynchronous, active-high reset; forces highway-green state.
- S  input  1  farm-road car sensor; 1 = car waiting; sampled on rising clk.
- light_highway  output  3  one-hot highway lamp: 3'b001 green, 3'b010 yellow, 3'b100 red.
- light_farm  output  3  one-hot farm lamp, same encoding.

## Operation
- States:
  - HG: highway green, farm red; outputs 001/100.
  - HY: highway yellow, farm red; outputs 010/100.
  - FG: highway red, farm green; outputs 100/001.
  - FY: highway red, farm yellow; outputs 100/010.
- Transitions, evaluated on each rising clk edge:
  - HG: S=1 → HY, clear yellow counter; S=0 → stay.
  - HY: counter counts cycles spent in HY; after YELLOW_CYCLES cycles → FG. S is ignored.
  - FG: S=1 → stay; S=0 → FY, clear counter.
  - FY: after YELLOW_CYCLES cycles → HG. S is ignored.
- Outputs are a pure decode of the registered state (Moore). No combinational path from S to the lamps.
- Invariant: at least one direction is red in every state; both greens are never on together.
- The yellow counter is ceil(log2(YELLOW_CYCLES+1)) bits wide. It saturates or clears and never wraps within a phase.

## Timing
- Reset value: state HG, counter 0, light_highway=3'b001, light_farm=3'b100. Reset takes effect immediately, asynchronously, and overrides all transitions.
- Reset asserted mid-yellow or in FG: the outputs return to HG at once and the counter clears.
- Request latency: S=1 sampled at edge N in HG → HY visible after edge N.
- Yellow dwell: HY or FY is visible for exactly YELLOW_CYCLES clock cycles; the next green appears on the following edge.
- Release latency: S=0 sampled at edge N in FG → FY after edge N.
- S toggling during yellow has no effect.
- S already high when HG is re-entered from FY: HY follows on the next edge.

## Configuration
- TRAFFIC_LIGHT_MIN_GREEN_EN:
  - Defined: HG holds for at least MIN_GREEN_CYCLES cycles after entry (including entry from reset) before S=1 is honoured. The dwell counter is reused. A pending S is honoured as soon as the minimum elapses.
  - Undefined (default): HG leaves on the first edge with S=1, as specified above. This is the baseline behaviour.

## Structure
- traffic_light_pkg holds:
  - the state enum (HG, HY, FG, FY);
  - lamp constants LAMP_GREEN=3'b001, LAMP_YELLOW=3'b010, LAMP_RED=3'b100.
- One sub-module, traffic_light_timer: a loadable/clearable down- or up-counter with a done flag, instantiated once. It times the yellow phases and, when enabled, the minimum green.
- The state register, next-state logic and output decode stay in traffic_light.

## Test plan
- Reset: assert rst with S=0 → highway 001, farm 100 immediately. Keep S=0 after release → stays 001/100.
- Request: S=1 in HG → four cycles of highway 010/farm 100, then 100/001 (YELLOW_CYCLES=4).
- Hold and release: S=1 held in FG → 100/001 persists. S=0 → four cycles of 100/010, then 001/100.
- Yellow immunity: toggle S every cycle during HY and FY → yellow still lasts exactly 4 cycles each.
- Mid-phase reset: assert rst during FY (or in FG with S=1) → 001/100 before the next clock edge. S=1 after release → HY on the next edge.
- Min-green build (TRAFFIC_LIGHT_MIN_GREEN_EN, MIN_GREEN_CYCLES=8): S=1 right after reset → highway stays 001 for 8 cycles, then 010.
